// File: rtl/alu_taylor_calc_pkg.sv
// Shared definitions for the Taylor-series ALU sequencer: function codes,
// Q2.16 constants, state encoding and fixed-point helpers.
package alu_taylor_calc_pkg;

    localparam int TAYLOR_N_TERMS = 11;

    // Taylor function codes understood by the coefficient table
    localparam logic [2:0] FN_SIN = 3'd0;
    localparam logic [2:0] FN_COS = 3'd1;
    localparam logic [2:0] FN_EXP = 3'd2;

    // Q2.16 constants
    localparam logic [17:0] ONE       = 18'h10000;
    localparam logic [17:0] MINUS_ONE = 18'h30000;
    localparam logic [17:0] Q_MAX     = 18'h1FFFF;
    localparam logic [17:0] Q_MIN     = 18'h20000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T_FACT,
        S_T_COEF,
        S_T_POW,
        S_DONE
    } state_t;

    // 1/n! in Q2.16, floor-rounded; terms beyond 8! underflow to zero
    function automatic logic [17:0] inv_fact(input logic [3:0] n);
        case (n)
            4'd0:    return 18'h10000;
            4'd1:    return 18'h10000;
            4'd2:    return 18'h08000;
            4'd3:    return 18'h02AAA;
            4'd4:    return 18'h00AAA;
            4'd5:    return 18'h00222;
            4'd6:    return 18'h0005B;
            4'd7:    return 18'h0000D;
            4'd8:    return 18'h00001;
            default: return 18'h00000;
        endcase
    endfunction

    // Q2.16 add with clamping instead of wrap-around
    function automatic logic [17:0] sat_add(input logic [17:0] a, input logic [17:0] b);
        logic [18:0] sum;
        sum = {a[17], a} + {b[17], b};
        if (sum[18] != sum[17])
            return sum[18] ? Q_MIN : Q_MAX;
        return sum[17:0];
    endfunction

endpackage

// File: rtl/alu_mul_q2_16.sv
// Signed Q2.16 x Q2.16 multiply: full 36-bit product, floor shift by 16,
// saturate when the shifted value does not fit in 18 bits.
module alu_mul_q2_16
    import alu_taylor_calc_pkg::*;
(
    input  logic signed [17:0] a,
    input  logic signed [17:0] b,
    output logic        [17:0] p
);

    logic signed [35:0] prod;

    // Product, truncation and saturation; bits [35:33] agree only when the result fits
    always_comb begin
        // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
        prod = 36'(a) * 36'(b);
        if (prod[35:33] == 3'b000 || prod[35:33] == 3'b111)
            p = prod[33:16];
        else
            p = prod[35] ? Q_MIN : Q_MAX;
    end

endmodule

// File: rtl/alu_taylor_calc.sv
// Sequencer/accumulator evaluating sum deriv(n) * x^n / n! over N_TERMS terms
// with a single shared Q2.16 multiplier, three cycles per term.
module alu_taylor_calc
    import alu_taylor_calc_pkg::*;
#(
    parameter int N_TERMS = TAYLOR_N_TERMS,
    parameter int IDX_W   = 4,
    parameter int DATA_W  = 18
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              do_calc,
    input  logic [2:0]        function_sel,
    input  logic [DATA_W-1:0] x_in,
    output logic              busy,
    output logic              calc_done,
    output logic [DATA_W-1:0] result,
    output logic [2:0]        coef_function_sel,
    output logic [IDX_W-1:0]  coef_idx,
    input  logic [DATA_W-1:0] coef_deriv
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TERMS - 1);

    state_t            state;
    logic [DATA_W-1:0] x_r;
    logic [DATA_W-1:0] pow;
    logic [DATA_W-1:0] term;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic [DATA_W-1:0] mul_p;

    // Operand mux for the shared multiplier, selected by the current step
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            S_T_FACT: begin
                mul_a = pow;
                mul_b = inv_fact(4'(coef_idx));
            end
            S_T_COEF: begin
                mul_a = term;
                mul_b = coef_deriv;
            end
            S_T_POW: begin
                mul_a = pow;
                mul_b = x_r;
            end
            default: ;
        endcase
    end

    alu_mul_q2_16 u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    // Control FSM and datapath registers; all outputs are registered
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!reset_n) begin
            state             <= S_IDLE;
            busy              <= 1'b0;
            calc_done         <= 1'b0;
            result            <= '0;
            coef_idx          <= '0;
            coef_function_sel <= '0;
            x_r               <= '0;
            pow               <= ONE;
            term              <= '0;
            acc               <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (do_calc) begin
                        x_r               <= x_in;
                        coef_function_sel <= function_sel;
                        acc               <= '0;
                        pow               <= ONE;
                        coef_idx          <= '0;
                        busy              <= 1'b1;
                        state             <= S_T_FACT;
                    end
                end
                S_T_FACT: begin
                    term  <= mul_p;
                    state <= S_T_COEF;
                end
                S_T_COEF: begin
                    acc   <= sat_add(acc, mul_p);
                    state <= S_T_POW;
                end
                S_T_POW: begin
                    pow <= mul_p;
                    if (coef_idx == LAST_IDX) begin
                        // acc is final here, so result is valid in the DONE cycle
                        result    <= acc;
                        calc_done <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        coef_idx <= coef_idx + IDX_W'(1);
                        state    <= S_T_FACT;
                    end
                end
                S_DONE: begin
                    calc_done <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_taylor_calc.sv
// Self-checking bench for alu_taylor_calc: directed cases from the test plan
// plus randomized operands against a plain-arithmetic series model.
module tb_alu_taylor_calc;

    localparam int N_TERMS  = 11;
    localparam int DONE_CYC = 1 + 3 * N_TERMS;
    localparam int BUDGET   = 60;

    localparam logic [2:0] F_SIN = 3'd0;
    localparam logic [2:0] F_COS = 3'd1;
    localparam logic [2:0] F_EXP = 3'd2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        do_calc;
    logic [2:0]  function_sel;
    logic [17:0] x_in;
    logic        busy;
    logic        calc_done;
    logic [17:0] result;
    logic [2:0]  coef_function_sel;
    logic [3:0]  coef_idx;
    logic [17:0] coef_deriv;
    bit          sat_table = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_taylor_calc dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .do_calc           (do_calc),
        .function_sel      (function_sel),
        .x_in              (x_in),
        .busy              (busy),
        .calc_done         (calc_done),
        .result            (result),
        .coef_function_sel (coef_function_sel),
        .coef_idx          (coef_idx),
        .coef_deriv        (coef_deriv)
    );

    // Derivative-at-zero table: sin cycles 0,1,0,-1; cos cycles 1,0,-1,0; exp is all 1
    function automatic logic [17:0] table_deriv(input logic [2:0] f, input logic [3:0] n);
        case (f)
            F_SIN:   return (n[1:0] == 2'd1) ? 18'h10000 : (n[1:0] == 2'd3) ? 18'h30000 : 18'h0;
            F_COS:   return (n[1:0] == 2'd0) ? 18'h10000 : (n[1:0] == 2'd2) ? 18'h30000 : 18'h0;
            F_EXP:   return 18'h10000;
            default: return 18'h0;
        endcase
    endfunction

    always_comb coef_deriv = sat_table ? 18'h1FFFF : table_deriv(coef_function_sel, coef_idx);

    // Reference arithmetic on plain integers
    function automatic longint clamp18(input longint v);
        if (v > 131071)  return 131071;
        if (v < -131072) return -131072;
        return v;
    endfunction

    function automatic longint q_mul(input longint a, input longint b);
        return clamp18((a * b) >>> 16);
    endfunction

    function automatic logic [17:0] model(input logic [2:0] f, input logic [17:0] x, input bit sat);
        longint pw, acc, term, fact, d, xi;
        pw   = 65536;
        acc  = 0;
        fact = 1;
        xi   = longint'($signed(x));
        for (int n = 0; n < N_TERMS; n++) begin
            if (n > 0) fact = fact * n;
            term = q_mul(pw, 65536 / fact);
            d    = sat ? 131071 : longint'($signed(table_deriv(f, n[3:0])));
            acc  = clamp18(acc + q_mul(term, d));
            pw   = q_mul(pw, xi);
        end
        return 18'(acc);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      32'(busy),              0);
        check({tag, "_done"},      32'(calc_done),         0);
        check({tag, "_result"},    32'(result),            0);
        check({tag, "_idx"},       32'(coef_idx),          0);
        check({tag, "_fsel"},      32'(coef_function_sel), 0);
    endtask

    // One calculation: start pulse, cycle-by-cycle observation, optional
    // do_calc re-assertion at cycles 5 and 20, optional reset at abort_k.
    task automatic run_calc(input string tag, input logic [2:0] f, input logic [17:0] x,
                            input int abort_k, input bit inject, output logic [17:0] res);
        int done_k, extra_done, busy_bad, idx_bad, fsel_bad;
        bit aborted;
        done_k     = -1;
        extra_done = 0;
        busy_bad   = 0;
        idx_bad    = 0;
        fsel_bad   = 0;
        aborted    = 1'b0;
        res        = 'x;
        @(negedge clk);
        function_sel = f;
        x_in         = x;
        do_calc      = 1'b1;
        @(negedge clk);
        do_calc      = 1'b0;
        function_sel = ~f;
        x_in         = ~x;
        for (int k = 1; k <= BUDGET; k++) begin
            if (k > 1) @(negedge clk);
            if (abort_k > 0 && k == abort_k + 1) begin
                check_reset_outputs({tag, "_abort"});
                reset_n = 1'b1;
            end
            if (!aborted && done_k < 0) begin
                if (busy !== 1'b1) busy_bad++;
                if (coef_function_sel !== f) fsel_bad++;
                if (k <= 3 * N_TERMS && coef_idx !== 4'((k - 1) / 3)) idx_bad++;
            end
            if (done_k > 0 && k == done_k + 1) begin
                check({tag, "_busy_after"}, 32'(busy), 0);
                check({tag, "_done_pulse"}, 32'(calc_done), 0);
            end
            if (calc_done === 1'b1) begin
                if (done_k < 0) begin
                    done_k = k;
                    res    = result;
                end else begin
                    extra_done++;
                end
            end
            do_calc = inject && (k == 5 || k == 20);
            if (k == abort_k) begin
                reset_n = 1'b0;
                aborted = 1'b1;
            end
        end
        do_calc = 1'b0;
        check({tag, "_done_cycle"}, 32'(done_k), (abort_k > 0) ? 32'hFFFF_FFFF : 32'(DONE_CYC));
        check({tag, "_busy_window"}, 32'(busy_bad), 0);
        check({tag, "_idx_seq"}, 32'(idx_bad), 0);
        check({tag, "_fsel_held"}, 32'(fsel_bad), 0);
        check({tag, "_extra_done"}, 32'(extra_done), 0);
        if (abort_k == 0) check({tag, "_result_hold"}, 32'(result), 32'(res));
    endtask

    function automatic int abs_diff(input logic [17:0] a, input logic [17:0] b);
        int d;
        d = int'($signed(a)) - int'($signed(b));
        return (d < 0) ? -d : d;
    endfunction

    initial begin
        logic [17:0] res;
        logic [2:0]  rf;
        logic [17:0] rx;

        reset_n      = 1'b0;
        do_calc      = 1'b0;
        function_sel = '0;
        x_in         = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        run_calc("sin_zero", F_SIN, 18'h00000, 0, 1'b0, res);
        check("sin_zero_result", 32'(res), 32'h00000);

        run_calc("cos_zero", F_COS, 18'h00000, 0, 1'b0, res);
        check("cos_zero_result", 32'(res), 32'h10000);

        run_calc("sin_half", F_SIN, 18'h08000, 0, 1'b0, res);
        check("sin_half_model", 32'(res), 32'(model(F_SIN, 18'h08000, 1'b0)));
        check("sin_half_tol", 32'(abs_diff(res, 18'h07ABC) <= 8), 1);

        run_calc("cos_one", F_COS, 18'h10000, 0, 1'b0, res);
        check("cos_one_model", 32'(res), 32'(model(F_COS, 18'h10000, 1'b0)));
        check("cos_one_tol", 32'(abs_diff(res, 18'h08A52) <= 8), 1);

        run_calc("sin_abort", F_SIN, 18'h08000, 15, 1'b0, res);

        run_calc("sin_fresh", F_SIN, 18'h08000, 0, 1'b0, res);
        check("sin_fresh_model", 32'(res), 32'(model(F_SIN, 18'h08000, 1'b0)));

        run_calc("unknown_fn", 3'b111, 18'h10000, 0, 1'b1, res);
        check("unknown_fn_result", 32'(res), 32'h00000);

        run_calc("exp_one", F_EXP, 18'h10000, 0, 1'b1, res);
        check("exp_one_model", 32'(res), 32'(model(F_EXP, 18'h10000, 1'b0)));

        sat_table = 1'b1;
        run_calc("sat", F_SIN, 18'h1FFFF, 0, 1'b0, res);
        check("sat_result", 32'(res), 32'h1FFFF);
        check("sat_model", 32'(res), 32'(model(F_SIN, 18'h1FFFF, 1'b1)));
        sat_table = 1'b0;

        for (int i = 0; i < 10; i++) begin
            rf = 3'($urandom_range(0, 7));
            rx = 18'($urandom);
            run_calc($sformatf("rand%0d", i), rf, rx, 0, 1'b0, res);
            check($sformatf("rand%0d_f%0d_x%05h", i, rf, rx), 32'(res), 32'(model(rf, rx, 1'b0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
